// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings for the RV32I hazard controller: forwarding selects,
// handshake FSM states and the register-write "none" mode.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RSTFLUSH = 2'd0,
        ST_IDLE     = 2'd1,
        ST_WAIT     = 2'd2
    } hz_state_e;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [2:0] NOREGWRITE = 3'b000;

    // MEM result wins over WB because it is the younger write to the same register.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       used,
        input logic [4:0] rd_m,
        input logic [2:0] rw_m,
        input logic [4:0] rd_w,
        input logic [2:0] rw_w
    );
        logic [1:0] sel;
        sel = FWD_REG;
        if (used && (rw_m != NOREGWRITE) && (rd_m != 5'd0) && (rd_m == rs))
            sel = FWD_MEM;
        else if (used && (rw_w != NOREGWRITE) && (rd_w != 5'd0) && (rd_w == rs))
            sel = FWD_WB;
        return sel;
    endfunction

endpackage

// File: rtl/dmem_handshake_fsm.sv
// Post-reset flush sequencing and the data-memory request/ack handshake,
// including the access timeout and the sticky error flag.
module dmem_handshake_fsm
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int RST_FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT      = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic mem_m_i,
    input  logic ack_i,
    output logic flush_all_o,
    output logic mem_stall_o,
    output logic dmem_req_o,
    output logic mem_err_o
);

    hz_state_e  state_q;
    logic [3:0] flush_cnt_q;
    logic [7:0] tmo_cnt_q;
    logic       mem_err_q;
    logic       tmo_last;

    assign tmo_last = (tmo_cnt_q == 8'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_RSTFLUSH;
            flush_cnt_q <= 4'(RST_FLUSH_CYCLES);
            tmo_cnt_q   <= 8'd0;
            mem_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_RSTFLUSH: begin
                    if (flush_cnt_q <= 4'd1)
                        state_q <= ST_IDLE;
                    else
                        flush_cnt_q <= flush_cnt_q - 4'd1;
                end
                ST_IDLE: begin
                    if (mem_m_i && !ack_i) begin
                        state_q   <= ST_WAIT;
                        tmo_cnt_q <= 8'd0;
                    end
                end
                ST_WAIT: begin
                    if (ack_i) begin
                        state_q <= ST_IDLE;
                    end else if (tmo_last) begin
                        state_q   <= ST_IDLE;
                        mem_err_q <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 8'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // The first un-acked cycle in IDLE must already hold the pipe, otherwise the
    // access would leave MEM before the memory answers. On timeout the stall is
    // released so the abandoned access moves on.
    always_comb begin
        flush_all_o = (state_q == ST_RSTFLUSH);
        dmem_req_o  = ((state_q == ST_IDLE) && mem_m_i) || (state_q == ST_WAIT);
        mem_stall_o = ((state_q == ST_IDLE) && mem_m_i && !ack_i) ||
                      ((state_q == ST_WAIT) && !ack_i && !tmo_last);
    end

    assign mem_err_o = mem_err_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I pipe: forwarding selects, load-use
// and control-transfer hazards, memory-wait stalls and a stall-cycle counter.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int RST_FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT      = 64,
    parameter int CNT_W            = 32
) (
    input  logic             CPU_CLK,
    input  logic             CPU_RST,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [1:0]       RegReadD,
    input  logic             JalD,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [1:0]       RegReadE,
    input  logic             MemToRegE,
    input  logic             BranchE,
    input  logic             JalrE,
    input  logic [4:0]       RdM,
    input  logic [2:0]       RegWriteM,
    input  logic             MemToRegM,
    input  logic [3:0]       MemWriteM,
    input  logic [4:0]       RdW,
    input  logic [2:0]       RegWriteW,
    input  logic             DMemAck,
    output logic             DMemReq,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             StallW,
    output logic             FlushF,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             FlushW,
    output logic [1:0]       Forward1E,
    output logic [1:0]       Forward2E,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCycles
);

    logic             mem_m;
    logic             flush_all;
    logic             mem_stall;
    logic             load_use;
    logic             ctrl_e;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    assign mem_m = MemToRegM || (MemWriteM != 4'd0);

    dmem_handshake_fsm #(
        .RST_FLUSH_CYCLES (RST_FLUSH_CYCLES),
        .MEM_TIMEOUT      (MEM_TIMEOUT)
    ) u_dmem_fsm (
        .clk_i       (CPU_CLK),
        .rst_i       (CPU_RST),
        .mem_m_i     (mem_m),
        .ack_i       (DMemAck),
        .flush_all_o (flush_all),
        .mem_stall_o (mem_stall),
        .dmem_req_o  (DMemReq),
        .mem_err_o   (MemErr)
    );

    assign Forward1E = fwd_sel(Rs1E, RegReadE[1], RdM, RegWriteM, RdW, RegWriteW);
    assign Forward2E = fwd_sel(Rs2E, RegReadE[0], RdM, RegWriteM, RdW, RegWriteW);

    assign load_use = MemToRegE && (RdE != 5'd0) &&
                      (((RdE == Rs1D) && RegReadD[1]) || ((RdE == Rs2D) && RegReadD[0]));
    assign ctrl_e   = BranchE || JalrE;

    // A frozen EX must keep its branch, so a memory stall masks every D/E action.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        StallW = 1'b0;
        FlushF = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushM = 1'b0;
        FlushW = 1'b0;
        if (flush_all) begin
            FlushF = 1'b1;
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushM = 1'b1;
            FlushW = 1'b1;
        end else if (mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (ctrl_e) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else begin
            FlushD = JalD;
            if (load_use) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (StallF && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
        if (CPU_RST)
            stall_cnt_q <= '0;
        else
            stall_cnt_q <= stall_cnt_d;
    end

    assign StallCycles = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a short timeout and a narrow
// stall counter so timeout and saturation are reachable in a few cycles.
module tb_pipeline_hazard_ctrl;

    logic       CPU_CLK = 1'b0;
    logic       CPU_RST;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0] RegReadD, RegReadE;
    logic       JalD, MemToRegE, BranchE, JalrE, MemToRegM, DMemAck;
    logic [2:0] RegWriteM, RegWriteW;
    logic [3:0] MemWriteM;
    logic       DMemReq, MemErr;
    logic       StallF, StallD, StallE, StallM, StallW;
    logic       FlushF, FlushD, FlushE, FlushM, FlushW;
    logic [1:0] Forward1E, Forward2E;
    logic [3:0] StallCycles;
    logic [4:0] stall_v, flush_v;

    int checks = 0;
    int errors = 0;

    assign stall_v = {StallF, StallD, StallE, StallM, StallW};
    assign flush_v = {FlushF, FlushD, FlushE, FlushM, FlushW};

    always #5 CPU_CLK = ~CPU_CLK;

    pipeline_hazard_ctrl #(
        .RST_FLUSH_CYCLES (2),
        .MEM_TIMEOUT      (4),
        .CNT_W            (4)
    ) dut (
        .CPU_CLK     (CPU_CLK),
        .CPU_RST     (CPU_RST),
        .Rs1D        (Rs1D),
        .Rs2D        (Rs2D),
        .RegReadD    (RegReadD),
        .JalD        (JalD),
        .Rs1E        (Rs1E),
        .Rs2E        (Rs2E),
        .RdE         (RdE),
        .RegReadE    (RegReadE),
        .MemToRegE   (MemToRegE),
        .BranchE     (BranchE),
        .JalrE       (JalrE),
        .RdM         (RdM),
        .RegWriteM   (RegWriteM),
        .MemToRegM   (MemToRegM),
        .MemWriteM   (MemWriteM),
        .RdW         (RdW),
        .RegWriteW   (RegWriteW),
        .DMemAck     (DMemAck),
        .DMemReq     (DMemReq),
        .StallF      (StallF),
        .StallD      (StallD),
        .StallE      (StallE),
        .StallM      (StallM),
        .StallW      (StallW),
        .FlushF      (FlushF),
        .FlushD      (FlushD),
        .FlushE      (FlushE),
        .FlushM      (FlushM),
        .FlushW      (FlushW),
        .Forward1E   (Forward1E),
        .Forward2E   (Forward2E),
        .MemErr      (MemErr),
        .StallCycles (StallCycles)
    );

    task automatic clear_inputs();
        Rs1D = 0; Rs2D = 0; RegReadD = 0; JalD = 0;
        Rs1E = 0; Rs2E = 0; RdE = 0; RegReadE = 0;
        MemToRegE = 0; BranchE = 0; JalrE = 0;
        RdM = 0; RegWriteM = 0; MemToRegM = 0; MemWriteM = 0;
        RdW = 0; RegWriteW = 0; DMemAck = 0;
    endtask

    task automatic next_cycle();
        @(posedge CPU_CLK);
        #1;
    endtask

    task automatic test_reset();
        CPU_RST = 1'b1;
        clear_inputs();
        MemToRegM = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            @(negedge CPU_CLK);
            checks++;
            if (flush_v !== 5'b11111 || stall_v !== 5'b00000 || DMemReq !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold flush=%b stall=%b req=%b want 11111 00000 0", flush_v, stall_v, DMemReq);
            end
        end
        next_cycle();
        CPU_RST = 1'b0;
        MemToRegM = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge CPU_CLK);
            checks++;
            if (flush_v !== 5'b11111 || stall_v !== 5'b00000) begin
                errors++;
                $display("FAIL rst_flush_cycle%0d flush=%b stall=%b want 11111 00000", i, flush_v, stall_v);
            end
            next_cycle();
        end
        @(negedge CPU_CLK);
        checks++;
        if (flush_v !== 5'b00000 || StallCycles !== 4'd0 || MemErr !== 1'b0) begin
            errors++;
            $display("FAIL rst_done flush=%b cnt=%0d err=%b want 00000 0 0", flush_v, StallCycles, MemErr);
        end
    endtask

    task automatic test_forwarding();
        next_cycle();
        RdM = 5; RegWriteM = 3'b010; RdW = 5; RegWriteW = 3'b010;
        Rs1E = 5; Rs2E = 5; RegReadE = 2'b10;
        @(negedge CPU_CLK);
        checks++;
        if (Forward1E !== 2'b10 || Forward2E !== 2'b00) begin
            errors++;
            $display("FAIL fwd_mem_prio f1=%b f2=%b want 10 00", Forward1E, Forward2E);
        end
        RdM = 0;
        #1;
        checks++;
        if (Forward1E !== 2'b01) begin
            errors++;
            $display("FAIL fwd_wb f1=%b want 01", Forward1E);
        end
        RdM = 5; RegWriteM = 3'b000; RegReadE = 2'b11;
        #1;
        checks++;
        if (Forward1E !== 2'b01 || Forward2E !== 2'b01) begin
            errors++;
            $display("FAIL fwd_nowrite_m f1=%b f2=%b want 01 01", Forward1E, Forward2E);
        end
        RegWriteM = 3'b001; RdW = 3; Rs1E = 9;
        #1;
        checks++;
        if (Forward1E !== 2'b00 || Forward2E !== 2'b10) begin
            errors++;
            $display("FAIL fwd_mixed f1=%b f2=%b want 00 10", Forward1E, Forward2E);
        end
        clear_inputs();
    endtask

    task automatic test_load_use();
        next_cycle();
        MemToRegE = 1; RdE = 7; Rs2D = 7; RegReadD = 2'b01;
        @(negedge CPU_CLK);
        checks++;
        if (stall_v !== 5'b11000 || flush_v !== 5'b00100) begin
            errors++;
            $display("FAIL load_use stall=%b flush=%b want 11000 00100", stall_v, flush_v);
        end
        next_cycle();
        BranchE = 1;
        @(negedge CPU_CLK);
        checks++;
        if (stall_v !== 5'b00000 || flush_v !== 5'b01100) begin
            errors++;
            $display("FAIL branch_over_lu stall=%b flush=%b want 00000 01100", stall_v, flush_v);
        end
        next_cycle();
        BranchE = 0; JalrE = 1;
        @(negedge CPU_CLK);
        checks++;
        if (stall_v !== 5'b00000 || flush_v !== 5'b01100) begin
            errors++;
            $display("FAIL jalr_over_lu stall=%b flush=%b want 00000 01100", stall_v, flush_v);
        end
        next_cycle();
        clear_inputs();
        JalD = 1; MemToRegE = 1; RdE = 0; Rs1D = 0; RegReadD = 2'b10;
        @(negedge CPU_CLK);
        checks++;
        if (stall_v !== 5'b00000 || flush_v !== 5'b01000) begin
            errors++;
            $display("FAIL jald_rd0 stall=%b flush=%b want 00000 01000", stall_v, flush_v);
        end
        next_cycle();
        clear_inputs();
        MemToRegE = 1; RdE = 7; Rs2D = 7; RegReadD = 2'b10;
        @(negedge CPU_CLK);
        checks++;
        if (stall_v !== 5'b00000 || flush_v !== 5'b00000) begin
            errors++;
            $display("FAIL lu_flag_off stall=%b flush=%b want 00000 00000", stall_v, flush_v);
        end
        next_cycle();
        clear_inputs();
        @(negedge CPU_CLK);
        checks++;
        if (StallCycles !== 4'd1) begin
            errors++;
            $display("FAIL lu_count got %0d want 1", StallCycles);
        end
    endtask

    task automatic test_mem_wait();
        next_cycle();
        MemWriteM = 4'h3; DMemAck = 1;
        @(negedge CPU_CLK);
        checks++;
        if (DMemReq !== 1'b1 || stall_v !== 5'b00000) begin
            errors++;
            $display("FAIL zero_wait req=%b stall=%b want 1 00000", DMemReq, stall_v);
        end
        next_cycle();
        clear_inputs();
        @(negedge CPU_CLK);
        checks++;
        if (DMemReq !== 1'b0 || stall_v !== 5'b00000) begin
            errors++;
            $display("FAIL zero_wait_idle req=%b stall=%b want 0 00000", DMemReq, stall_v);
        end
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            MemToRegM = 1; DMemAck = 0;
            @(negedge CPU_CLK);
            checks++;
            if (DMemReq !== 1'b1 || stall_v !== 5'b11110 || flush_v !== 5'b00001) begin
                errors++;
                $display("FAIL wait_cycle%0d req=%b stall=%b flush=%b want 1 11110 00001", i, DMemReq, stall_v, flush_v);
            end
        end
        next_cycle();
        DMemAck = 1;
        @(negedge CPU_CLK);
        checks++;
        if (DMemReq !== 1'b1 || stall_v !== 5'b00000 || flush_v !== 5'b00000) begin
            errors++;
            $display("FAIL wait_ack req=%b stall=%b flush=%b want 1 00000 00000", DMemReq, stall_v, flush_v);
        end
        next_cycle();
        clear_inputs();
        @(negedge CPU_CLK);
        checks++;
        if (DMemReq !== 1'b0 || stall_v !== 5'b00000 || StallCycles !== 4'd4) begin
            errors++;
            $display("FAIL wait_done req=%b stall=%b cnt=%0d want 0 00000 4", DMemReq, stall_v, StallCycles);
        end
    endtask

    task automatic test_branch_in_wait();
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            MemToRegM = 1; BranchE = 1;
            MemToRegE = 1; RdE = 7; Rs2D = 7; RegReadD = 2'b01;
            @(negedge CPU_CLK);
            checks++;
            if (stall_v !== 5'b11110 || flush_v !== 5'b00001) begin
                errors++;
                $display("FAIL br_wait%0d stall=%b flush=%b want 11110 00001", i, stall_v, flush_v);
            end
        end
        next_cycle();
        DMemAck = 1;
        @(negedge CPU_CLK);
        checks++;
        if (stall_v !== 5'b00000 || flush_v !== 5'b01100) begin
            errors++;
            $display("FAIL br_ack stall=%b flush=%b want 00000 01100", stall_v, flush_v);
        end
        next_cycle();
        clear_inputs();
        @(negedge CPU_CLK);
        checks++;
        if (StallCycles !== 4'd6) begin
            errors++;
            $display("FAIL br_count got %0d want 6", StallCycles);
        end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            MemToRegM = 1;
            @(negedge CPU_CLK);
            checks++;
            if (DMemReq !== 1'b1 || stall_v !== 5'b11110 || MemErr !== 1'b0) begin
                errors++;
                $display("FAIL tmo_stall%0d req=%b stall=%b err=%b want 1 11110 0", i, DMemReq, stall_v, MemErr);
            end
        end
        next_cycle();
        @(negedge CPU_CLK);
        checks++;
        if (DMemReq !== 1'b1 || stall_v !== 5'b00000 || flush_v !== 5'b00000) begin
            errors++;
            $display("FAIL tmo_release req=%b stall=%b flush=%b want 1 00000 00000", DMemReq, stall_v, flush_v);
        end
        next_cycle();
        clear_inputs();
        @(negedge CPU_CLK);
        checks++;
        if (MemErr !== 1'b1 || DMemReq !== 1'b0 || StallCycles !== 4'd10) begin
            errors++;
            $display("FAIL tmo_err err=%b req=%b cnt=%0d want 1 0 10", MemErr, DMemReq, StallCycles);
        end
        next_cycle();
        MemWriteM = 4'h1;
        @(negedge CPU_CLK);
        checks++;
        if (DMemReq !== 1'b1 || stall_v !== 5'b11110) begin
            errors++;
            $display("FAIL post_tmo_req req=%b stall=%b want 1 11110", DMemReq, stall_v);
        end
        next_cycle();
        DMemAck = 1;
        @(negedge CPU_CLK);
        checks++;
        if (DMemReq !== 1'b1 || stall_v !== 5'b00000) begin
            errors++;
            $display("FAIL post_tmo_ack req=%b stall=%b want 1 00000", DMemReq, stall_v);
        end
        next_cycle();
        clear_inputs();
        @(negedge CPU_CLK);
        checks++;
        if (MemErr !== 1'b1 || DMemReq !== 1'b0 || StallCycles !== 4'd11) begin
            errors++;
            $display("FAIL err_sticky err=%b req=%b cnt=%0d want 1 0 11", MemErr, DMemReq, StallCycles);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            MemToRegE = 1; RdE = 3; Rs1D = 3; RegReadD = 2'b10;
        end
        next_cycle();
        clear_inputs();
        @(negedge CPU_CLK);
        checks++;
        if (StallCycles !== 4'd15) begin
            errors++;
            $display("FAIL saturate got %0d want 15", StallCycles);
        end
    endtask

    task automatic test_reset_abort();
        next_cycle();
        MemToRegM = 1;
        next_cycle();
        @(negedge CPU_CLK);
        checks++;
        if (stall_v !== 5'b11110 || DMemReq !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre stall=%b req=%b want 11110 1", stall_v, DMemReq);
        end
        #1;
        CPU_RST = 1'b1;
        #1;
        checks++;
        if (DMemReq !== 1'b0 || flush_v !== 5'b11111 || stall_v !== 5'b00000 ||
            MemErr !== 1'b0 || StallCycles !== 4'd0) begin
            errors++;
            $display("FAIL abort_rst req=%b flush=%b stall=%b err=%b cnt=%0d want 0 11111 00000 0 0",
                     DMemReq, flush_v, stall_v, MemErr, StallCycles);
        end
        next_cycle();
        CPU_RST = 1'b0;
        clear_inputs();
        repeat (3) next_cycle();
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_mem_wait();
        test_branch_in_wait();
        test_timeout();
        test_saturation();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB).
- Consumes the decoder's per-instruction control fields (RegRead, RegWrite, MemToReg, MemWrite, Jal/Jalr, branch outcome) as they flow down the pipe.
- Produces per-stage stall/flush and EX forwarding selects.
- Also owns the data-memory request/acknowledge handshake, the post-reset flush sequence and a stall-cycle performance counter.

Parameters:
RST_FLUSH_CYCLES, 2, cycles all stages are flushed after reset deasserts (1..15)
MEM_TIMEOUT, 64, max WAIT cycles before abandoning a data-memory access (2..255)
CNT_W, 32, width of stall-cycle counter

Ports:
CPU_CLK  in  1  clock, rising edge
CPU_RST  in  1  reset
Rs1D, Rs2D  in  5  source regs of instruction in ID
RegReadD  in  2  [1]=rs1 used, [0]=rs2 used, ID stage
JalD  in  1  jal decoded in ID
Rs1E, Rs2E, RdE  in  5  EX-stage register fields
RegReadE  in  2  EX-stage register-use flags
MemToRegE  in  1  EX instruction is a load
BranchE  in  1  EX branch resolved taken
JalrE  in  1  EX instruction is jalr
RdM  in  5  MEM-stage dest
RegWriteM  in  3  MEM write mode, 0 = no write
MemToRegM  in  1  MEM instruction is a load
MemWriteM  in  4  MEM byte-write mask
RdW  in  5  WB-stage dest
RegWriteW  in  3  WB write mode, 0 = no write
DMemAck  in  1  data memory completes current access
DMemReq  out  1  data-memory access request
StallF, StallD, StallE, StallM, StallW  out  1 each  hold stage register
FlushF, FlushD, FlushE, FlushM, FlushW  out  1 each  clear stage register to bubble
Forward1E, Forward2E  out  2  00 = regfile, 10 = MEM result, 01 = WB result
MemErr  out  1  sticky timeout flag
StallCycles  out  CNT_W  saturating count of cycles with StallF=1

Behaviour:
- Reset is asynchronous and active-high on CPU_RST, single clock CPU_CLK.
- Reset values:
  - state = RSTFLUSH, flush counter = RST_FLUSH_CYCLES, MemErr = 0, StallCycles = 0.
  - While CPU_RST=1: all Flush* = 1, all Stall* = 0, DMemReq = 0.
- State machine (registered): RSTFLUSH, IDLE, WAIT.
  - RSTFLUSH: all Flush* = 1, Stall* = 0, DMemReq = 0; counter decrements each cycle; when it reaches 1, go to IDLE. Net effect: exactly RST_FLUSH_CYCLES flushed cycles after reset release.
  - IDLE: memM = MemToRegM | (MemWriteM != 0).
    - DMemReq = memM (combinational).
    - memM & DMemAck: zero-wait access, no stall, stay in IDLE.
    - memM & !DMemAck: go to WAIT, clear timeout counter.
  - WAIT: DMemReq = 1; StallF/D/E/M = 1, FlushW = 1; timeout counter increments.
    - DMemAck: release the stall in that same cycle (combinational) and go to IDLE.
    - Counter reaches MEM_TIMEOUT-1 without ack: set MemErr, release the stall and go to IDLE; the access is dropped.
- Forwarding (combinational, applied to Forward1E using Rs1E/RegReadE[1], and Forward2E using Rs2E/RegReadE[0]):
  - 10 if RegWriteM != 0, RdM != 0, RdM == RsE and the use flag is set.
  - else 01 if the same conditions hold for RdW/RegWriteW.
  - else 00. MEM has priority over WB.
- Load-use: MemToRegE & RdE != 0 & ((RdE == Rs1D & RegReadD[1]) | (RdE == Rs2D & RegReadD[0])) gives StallF, StallD, FlushE for one cycle.
- Control transfer:
  - BranchE | JalrE gives FlushD, FlushE.
  - JalD gives FlushD.
  - A branch/jalr flush dominates a simultaneous load-use stall: the stall is suppressed because the load-use victim in ID is squashed.
- Priority, highest first:
  1. Reset/RSTFLUSH.
  2. WAIT stall: suppresses all load-use stalls and D/E flushes, since EX is frozen and the branch must survive.
  3. Control-transfer flush.
  4. Load-use.
- FlushF is 0 outside RSTFLUSH. StallW is always 0.
- StallCycles increments on every cycle with StallF=1 and saturates at all-ones. Its reset value is 0.
- MemErr clears only on reset.
- Reset asserted mid-WAIT aborts the access immediately: DMemReq drops asynchronously.

Decomposition:
- Shared package (alongside the existing Parameters header): forwarding select encodings (FWD_REG=00, FWD_WB=01, FWD_MEM=10), FSM state encodings, and the NOREGWRITE encoding.
- One natural sub-module, dmem_handshake_fsm: contains the RSTFLUSH/IDLE/WAIT state, the counters, DMemReq and MemErr.
- The top-level holds the combinational forwarding/hazard logic and the priority merge.

Test Plan:
1. Reset sequence: assert CPU_RST for 3 cycles, release -> all Flush*=1 exactly 2 cycles after release, then 0. StallCycles=0, MemErr=0.
2. Forwarding: RdM=5, RegWriteM=3'b010, RdW=5, RegWriteW=3'b010, Rs1E=5, RegReadE=2'b10 -> Forward1E=10, Forward2E=00. Then RdM=0 -> Forward1E=01.
3. Load-use: MemToRegE=1, RdE=7, Rs2D=7, RegReadD=2'b01 -> StallF=StallD=FlushE=1 for 1 cycle; StallCycles increments by 1.
4. Memory wait: load in MEM, DMemAck low 3 cycles then high -> DMemReq high 4 cycles; StallF..M=1 and FlushW=1 for 3 cycles, released in the ack cycle; state returns to IDLE.
5. Branch during WAIT: BranchE=1 while in WAIT -> FlushD=FlushE=0 until ack. In the ack cycle, FlushD=FlushE=1.
6. Timeout: MEM_TIMEOUT=4, no ack -> stall for 4 cycles, MemErr=1 and stays set; the next memory access still handshakes normally.
